// File: rtl/tb_sb_pkg.sv
// -----------------------------------------------------------------------------
// tb_sb_pkg
// Shared definitions for the in-order result scoreboard.
//   - sb_state_e : scoreboard FSM states (RUN, DRAIN, DONE)
//   - sat_inc    : saturating +1 on a counter value, bounded by max_v
//   - DEF_*      : default parameter values used by tb_scoreboard
// -----------------------------------------------------------------------------
package tb_sb_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    SB_RUN   = 2'd0,
    SB_DRAIN = 2'd1,
    SB_DONE  = 2'd2
  } sb_state_e;

  // Counters are carried through a 64-bit container so one function serves
  // any counter width up to 64; the caller truncates back to its width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                          input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/tb_sb_fifo.sv
// -----------------------------------------------------------------------------
// tb_sb_fifo
// Synchronous FIFO with a show-ahead head word.
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers that
// differ only in the wrap bit mean full.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset (empties the FIFO)
//   flush    in   synchronous flush, same effect as rst on the pointers
//   wr_en    in   write request; ignored while full
//   wr_data  in   DATA_W write word
//   rd_en    in   pop request; ignored while empty
//   rd_data  out  DATA_W head word (valid whenever empty is low)
//   full     out  FIFO holds DEPTH words
//   empty    out  FIFO holds no words
//   count    out  occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module tb_sb_fifo #(
  parameter int  DATA_W = 16,
  parameter int  DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Storage needs no reset: a word is only ever read after being written.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/tb_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_scoreboard
// In-order result scoreboard. Expected words from the reference model are
// queued; each DUT result pops the head and is compared against it. Pass/fail
// statistics are kept in saturating counters and become final once done rises.
//
// Optional feature: define TB_SB_FAIL_CAPTURE_EN to latch the first failure
// (index, expected, actual) and print every data mismatch. Without it the
// first_fail_* outputs are tied to 0.
//
// Handshake: the expected-word port is valid/ready - a word is taken on a
// cycle where exp_valid and exp_ready are both high; exp_valid while not
// ready drops the word (overflow). act_valid has no ready: every result is
// taken in the cycle it is presented.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   exp_valid/ready expected-word handshake, exp_data the word
//   act_valid       DUT result present, act_data the result
//   end_of_test     single-cycle pulse, stimulus finished (RUN -> DRAIN)
//   iterations      number of comparisons (incl. underflows and lost words)
//   failures        mismatches + underflows + words lost to the watchdog
//   underflow       sticky, result arrived with the queue empty
//   overflow        sticky, expected word offered while the queue was full
//   timeout         sticky, DRAIN watchdog expired
//   done            high once the scoreboard has reached DONE, until reset
//   first_fail_*    index/expected/actual of the first failure
//   state           FSM state, for observation
// -----------------------------------------------------------------------------
module tb_scoreboard
  import tb_sb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              act_valid,
  input  logic [DATA_W-1:0] act_data,
  input  logic              end_of_test,
  output logic [CNT_W-1:0]  iterations,
  output logic [CNT_W-1:0]  failures,
  output logic              underflow,
  output logic              overflow,
  output logic              timeout,
  output logic              done,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_act,
  output sb_state_e         state
);

  localparam int               AW      = $clog2(DEPTH);
  localparam int               WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Expected-word queue
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;

  logic              active;
  logic              push;
  logic              pop;
  logic              uflow_ev;
  logic              oflow_ev;
  logic              mismatch;
  logic              wd_fire;

  // DONE freezes everything: no pushes, pops or flag updates.
  assign active    = (state != SB_DONE);
  assign exp_ready = active && !fifo_full;
  assign push      = exp_valid && exp_ready;
  assign oflow_ev  = exp_valid && active && fifo_full;

  // Emptiness is judged on the registered pointers, so a word pushed in the
  // same cycle cannot satisfy a result in that cycle.
  assign pop       = act_valid && active && !fifo_empty;
  assign uflow_ev  = act_valid && active && fifo_empty;
  assign mismatch  = pop && (head != act_data);

  tb_sb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (wd_fire),
    .wr_en   (push),
    .wr_data (exp_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // DRAIN watchdog
  // wd counts consecutive idle DRAIN cycles. It fires on the edge where it
  // would reach TIMEOUT; done/timeout then appear one cycle later, together.
  // An empty, idle queue finishes normally and never fires the watchdog.
  // ---------------------------------------------------------------------------
  logic [WD_W-1:0] wd;

  assign wd_fire = (state == SB_DRAIN) && !act_valid && !fifo_empty &&
                   (wd == WD_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // Counter next values
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] iter_inc;
  logic [CNT_W-1:0] fail_inc;
  logic [CNT_W:0]   iter_sum;
  logic [CNT_W:0]   fail_sum;
  logic [CNT_W-1:0] iter_add;
  logic [CNT_W-1:0] fail_add;

  assign iter_inc = CNT_W'(sat_inc(64'(iterations), 64'(CNT_MAX)));
  assign fail_inc = CNT_W'(sat_inc(64'(failures), 64'(CNT_MAX)));

  // Words still queued when the watchdog fires are charged as failed
  // comparisons; the extra carry bit detects saturation.
  assign iter_sum = {1'b0, iterations} + {1'b0, CNT_W'(fifo_count)};
  assign fail_sum = {1'b0, failures} + {1'b0, CNT_W'(fifo_count)};
  assign iter_add = iter_sum[CNT_W] ? CNT_MAX : iter_sum[CNT_W-1:0];
  assign fail_add = fail_sum[CNT_W] ? CNT_MAX : fail_sum[CNT_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM with registered status outputs
  // ---------------------------------------------------------------------------
  logic to_hit;  // DONE was entered through the watchdog

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SB_RUN;
      wd     <= '0;
      to_hit <= 1'b0;
      done   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        SB_RUN: begin
          if (end_of_test) begin
            state <= SB_DRAIN;
            wd    <= '0;
          end
        end
        SB_DRAIN: begin
          if (fifo_empty && !act_valid) begin
            state <= SB_DONE;
          end else if (act_valid) begin
            wd <= '0;
          end else if (wd_fire) begin
            state  <= SB_DONE;
            to_hit <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        SB_DONE: begin
          done <= 1'b1;
          if (to_hit) begin
            timeout <= 1'b1;
          end
        end
        default: begin
          state <= SB_RUN;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics and sticky flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      iterations <= '0;
      failures   <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop || uflow_ev) begin
        iterations <= iter_inc;
      end else if (wd_fire) begin
        iterations <= iter_add;
      end

      if (mismatch || uflow_ev) begin
        failures <= fail_inc;
      end else if (wd_fire) begin
        failures <= fail_add;
      end

      if (uflow_ev) begin
        underflow <= 1'b1;
      end
      if (oflow_ev) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First-failure capture
  // ---------------------------------------------------------------------------
`ifdef TB_SB_FAIL_CAPTURE_EN
  logic              fail_ev;
  logic              captured;
  logic [CNT_W-1:0]  ff_idx;
  logic [DATA_W-1:0] ff_exp;
  logic [DATA_W-1:0] ff_act;

  assign fail_ev = mismatch || uflow_ev || wd_fire;

  // The index is the pre-increment iteration count of the failing event.
  // An underflow has no expected word and a timeout has no actual word.
  always_ff @(posedge clk) begin
    if (rst) begin
      captured <= 1'b0;
      ff_idx   <= '0;
      ff_exp   <= '0;
      ff_act   <= '0;
    end else if (fail_ev && !captured) begin
      captured <= 1'b1;
      ff_idx   <= iterations;
      ff_exp   <= uflow_ev ? '0 : head;
      ff_act   <= wd_fire  ? '0 : act_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mismatch) begin
      $display("tb_scoreboard: mismatch idx=%0d exp=0x%0h act=0x%0h",
               iterations, head, act_data);
    end
  end

  assign first_fail_idx = ff_idx;
  assign first_fail_exp = ff_exp;
  assign first_fail_act = ff_act;
`else
  assign first_fail_idx = '0;
  assign first_fail_exp = '0;
  assign first_fail_act = '0;
`endif

endmodule

// File: tb/tb_tb_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_tb_scoreboard
// Directed bench for tb_scoreboard. A queue model of the expected-word store
// (exp_q) plus model counters predict iterations/failures/flags; status
// timing (done, timeout) is checked against fixed cycle counts.
// Honours TB_SB_FAIL_CAPTURE_EN for the first_fail_* checks.
// -----------------------------------------------------------------------------
module tb_tb_scoreboard;
  import tb_sb_pkg::*;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 20;

  logic              clk;
  logic              rst;
  logic              exp_valid;
  logic              exp_ready;
  logic [DATA_W-1:0] exp_data;
  logic              act_valid;
  logic [DATA_W-1:0] act_data;
  logic              end_of_test;
  logic [CNT_W-1:0]  iterations;
  logic [CNT_W-1:0]  failures;
  logic              underflow;
  logic              overflow;
  logic              timeout;
  logic              done;
  logic [CNT_W-1:0]  first_fail_idx;
  logic [DATA_W-1:0] first_fail_exp;
  logic [DATA_W-1:0] first_fail_act;
  sb_state_e         state;

  tb_scoreboard #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_data       (exp_data),
    .act_valid      (act_valid),
    .act_data       (act_data),
    .end_of_test    (end_of_test),
    .iterations     (iterations),
    .failures       (failures),
    .underflow      (underflow),
    .overflow       (overflow),
    .timeout        (timeout),
    .done           (done),
    .first_fail_idx (first_fail_idx),
    .first_fail_exp (first_fail_exp),
    .first_fail_act (first_fail_act),
    .state          (state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoreboard model
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [CNT_W-1:0]  m_iter;
  logic [CNT_W-1:0]  m_fail;
  logic              m_uflow;
  logic              m_oflow;
  logic              m_done;
`ifdef TB_SB_FAIL_CAPTURE_EN
  logic              m_cap;
  logic [CNT_W-1:0]  m_ff_idx;
  logic [DATA_W-1:0] m_ff_exp;
  logic [DATA_W-1:0] m_ff_act;
`endif

  task automatic model_clear();
    exp_q.delete();
    m_iter  = '0;
    m_fail  = '0;
    m_uflow = 1'b0;
    m_oflow = 1'b0;
    m_done  = 1'b0;
`ifdef TB_SB_FAIL_CAPTURE_EN
    m_cap    = 1'b0;
    m_ff_idx = '0;
    m_ff_exp = '0;
    m_ff_act = '0;
`endif
  endtask

  task automatic model_fail_event(input logic [DATA_W-1:0] e,
                                  input logic [DATA_W-1:0] a);
`ifdef TB_SB_FAIL_CAPTURE_EN
    if (!m_cap) begin
      m_cap    = 1'b1;
      m_ff_idx = m_iter;
      m_ff_exp = e;
      m_ff_act = a;
    end
`else
    if (e == a) m_fail = m_fail;  // no capture in this build
`endif
    m_fail = m_fail + 1;
  endtask

  // One clock of stimulus as seen by the model: underflow is judged on the
  // occupancy before this cycle's push, and a push is refused when the
  // queue was full at the start of the cycle.
  task automatic model_step(input logic ev, input logic [DATA_W-1:0] ed,
                            input logic av, input logic [DATA_W-1:0] ad);
    int pre;
    logic [DATA_W-1:0] e;
    if (m_done) return;
    pre = exp_q.size();
    if (av) begin
      if (pre == 0) begin
        m_uflow = 1'b1;
        model_fail_event('0, ad);
      end else begin
        e = exp_q.pop_front();
        if (e != ad) model_fail_event(e, ad);
      end
      m_iter = m_iter + 1;
    end
    if (ev) begin
      if (pre < DEPTH) exp_q.push_back(ed);
      else m_oflow = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
      $error("%s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".iterations"}, 64'(iterations), 64'(m_iter));
    chk({tag, ".failures"},   64'(failures),   64'(m_fail));
    chk({tag, ".underflow"},  64'(underflow),  64'(m_uflow));
    chk({tag, ".overflow"},   64'(overflow),   64'(m_oflow));
  endtask

  task automatic chk_first_fail(input string tag);
`ifdef TB_SB_FAIL_CAPTURE_EN
    chk({tag, ".ff_idx"}, 64'(first_fail_idx), 64'(m_ff_idx));
    chk({tag, ".ff_exp"}, 64'(first_fail_exp), 64'(m_ff_exp));
    chk({tag, ".ff_act"}, 64'(first_fail_act), 64'(m_ff_act));
`else
    chk({tag, ".ff_idx"}, 64'(first_fail_idx), 64'd0);
    chk({tag, ".ff_exp"}, 64'(first_fail_exp), 64'd0);
    chk({tag, ".ff_act"}, 64'(first_fail_act), 64'd0);
`endif
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".iterations"}, 64'(iterations), 64'd0);
    chk({tag, ".failures"},   64'(failures),   64'd0);
    chk({tag, ".underflow"},  64'(underflow),  64'd0);
    chk({tag, ".overflow"},   64'(overflow),   64'd0);
    chk({tag, ".timeout"},    64'(timeout),    64'd0);
    chk({tag, ".done"},       64'(done),       64'd0);
    chk({tag, ".exp_ready"},  64'(exp_ready),  64'd1);
    chk({tag, ".ff_idx"},     64'(first_fail_idx), 64'd0);
    chk({tag, ".ff_exp"},     64'(first_fail_exp), 64'd0);
    chk({tag, ".ff_act"},     64'(first_fail_act), 64'd0);
    chk({tag, ".state"},      64'(state),      64'(SB_RUN));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: inputs change on the falling edge, outputs are read on the
  // falling edge after the rising edge that consumed them.
  // ---------------------------------------------------------------------------
  task automatic drive(input logic ev, input logic [DATA_W-1:0] ed,
                       input logic av, input logic [DATA_W-1:0] ad,
                       input logic eot);
    exp_valid   = ev;
    exp_data    = ed;
    act_valid   = av;
    act_data    = ad;
    end_of_test = eot;
    model_step(ev, ed, av, ad);
    @(negedge clk);
    exp_valid   = 1'b0;
    act_valid   = 1'b0;
    end_of_test = 1'b0;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    drive(1'b1, w, 1'b0, '0, 1'b0);
  endtask

  task automatic return_word(input logic [DATA_W-1:0] w, input logic eot);
    drive(1'b0, '0, 1'b1, w, eot);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    exp_valid   = 1'b0;
    act_valid   = 1'b0;
    end_of_test = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [DATA_W-1:0] w;

    rst         = 1'b1;
    exp_valid   = 1'b0;
    exp_data    = '0;
    act_valid   = 1'b0;
    act_data    = '0;
    end_of_test = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_values("reset");

    // --- in-order matching results, end_of_test with the last compare ------
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    return_word(16'h1111, 1'b0);
    chk("match.iter_after_first", 64'(iterations), 64'd1);
    return_word(16'h2222, 1'b0);
    return_word(16'h3333, 1'b1);
    chk_stats("match");
    chk("match.state_drain", 64'(state), 64'(SB_DRAIN));
    chk("match.done_plus1", 64'(done), 64'd0);
    idle();
    chk("match.done_plus1b", 64'(done), 64'd0);
    idle();
    chk("match.done_plus2", 64'(done), 64'd1);
    chk("match.exp_ready_done", 64'(exp_ready), 64'd0);
    chk("match.timeout", 64'(timeout), 64'd0);
    m_done = 1'b1;
    chk_stats("match.final");

    // --- one data mismatch -------------------------------------------------
    do_reset();
    chk_reset_values("reset2");
    push_word(16'h00AA);
    push_word(16'h00BB);
    return_word(16'h00AA, 1'b0);
    return_word(16'h00BC, 1'b0);
    chk_stats("mismatch");
    chk("mismatch.failures_one", 64'(failures), 64'd1);
    chk_first_fail("mismatch");

    // --- underflow ---------------------------------------------------------
    do_reset();
    return_word(16'h5A5A, 1'b0);
    chk_stats("underflow");
    chk("underflow.flag", 64'(underflow), 64'd1);
    chk_first_fail("underflow");

    // --- fill, overflow, then watchdog timeout ------------------------------
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      chk($sformatf("fill.exp_ready_%0d", i), 64'(exp_ready),
          (i < DEPTH) ? 64'd1 : 64'd0);
      push_word(DATA_W'(16'hC000 + i));
    end
    chk_stats("fill");
    chk("fill.overflow", 64'(overflow), 64'd1);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    n = 0;
    while (done !== 1'b1 && n < 4 * TIMEOUT) begin
      chk("drain.timeout_early", 64'(timeout), 64'd0);
      idle();
      n++;
    end
    chk("drain.timeout_latency", 64'(n), 64'(TIMEOUT + 1));
    chk("drain.timeout", 64'(timeout), 64'd1);
`ifdef TB_SB_FAIL_CAPTURE_EN
    if (!m_cap) begin
      m_cap    = 1'b1;
      m_ff_idx = m_iter;
      m_ff_exp = exp_q[0];
      m_ff_act = '0;
    end
`endif
    m_iter = m_iter + CNT_W'(exp_q.size());
    m_fail = m_fail + CNT_W'(exp_q.size());
    exp_q.delete();
    m_done = 1'b1;
    chk_stats("timeout");
    chk("timeout.failures_eight", 64'(failures), 64'd8);
    chk_first_fail("timeout");
    // DONE ignores everything
    drive(1'b1, 16'h1234, 1'b1, 16'h9999, 1'b1);
    idle();
    chk_stats("done_frozen");
    chk("done_frozen.done", 64'(done), 64'd1);

    // --- sustained simultaneous push/pop with pointer wrap ------------------
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_word(DATA_W'($urandom_range(0, 16'hFFFF)));
    end
    for (int i = 0; i < 20; i++) begin
      w = DATA_W'($urandom_range(0, 16'hFFFF));
      drive(1'b1, w, 1'b1, exp_q[0], 1'b0);
      chk($sformatf("wrap.exp_ready_%0d", i), 64'(exp_ready), 64'd1);
    end
    chk_stats("wrap");
    chk("wrap.model_occupancy", 64'(exp_q.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      return_word(exp_q[0], 1'b0);
    end
    chk_stats("wrap.drained");
    chk("wrap.iter25", 64'(iterations), 64'd25);
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    idle();
    idle();
    chk("wrap.done", 64'(done), 64'd1);
    chk("wrap.timeout", 64'(timeout), 64'd0);
    chk("wrap.underflow", 64'(underflow), 64'd0);

    // --- reset in the middle of DRAIN ---------------------------------------
    do_reset();
    push_word(16'h0101);
    push_word(16'h0202);
    push_word(16'h0303);
    return_word(16'h0101, 1'b1);
    chk("midrst.state_drain", 64'(state), 64'(SB_DRAIN));
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values("midrst");
    rst = 1'b0;
    model_clear();
    // Nothing survives the reset: the next result must underflow.
    return_word(16'h0202, 1'b0);
    chk_stats("midrst.after");
    chk("midrst.after_underflow", 64'(underflow), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
